// File: rtl/bram_sdp.sv
// Simple dual-port block RAM with byte write enables on port A, a
// registered read on port B, an optional output pipeline register and a
// power-up sweep that zeroes every entry before user traffic is accepted.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_INIT  | sweep writes zero to entry cnt each cycle; user traffic ignored
// S_READY | normal operation; held until reset
module bram_sdp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int WRITE_MODE = 0,
   parameter int OUT_REG    = 0
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [DATA_WIDTH/8-1:0] wea,
   input  logic [ADDR_WIDTH-1:0]   addra,
   input  logic [DATA_WIDTH-1:0]   dina,
   input  logic                    enb,
   input  logic [ADDR_WIDTH-1:0]   addrb,
   output logic [DATA_WIDTH-1:0]   doutb,
   output logic                    doutb_valid,
   output logic                    init_done
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [NB-1:0]           mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    rd_fire;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic [DATA_WIDTH-1:0]   rd_q;
   logic                    rd_vld_q;

   // FSM and sweep counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: sweep one entry per cycle, leave INIT after the last entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = S_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READY: begin
            state_d = S_READY;
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Write port mux: the sweep owns the array during INIT
   always_comb begin
      mem_we    = '0;
      mem_waddr = addra;
      mem_wdata = dina;
      if (state_q == S_INIT) begin
         mem_we    = '1;
         mem_waddr = cnt_q;
         mem_wdata = '0;
      end else begin
         mem_we    = wea;
      end
   end

   assign rd_fire   = (state_q == S_READY) && enb;
   assign init_done = (state_q == S_READY);

   // Read word; write-first mode forwards the enabled bytes of a colliding write
   always_comb begin
      rd_word = mem_q[addrb];
      if ((WRITE_MODE == 1) && (mem_waddr == addrb)) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_we[i]) begin
               rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // Memory array write; contents are cleared only by the sweep, never by reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (mem_we[i]) begin
            mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // First read stage: data holds its last value when no read is accepted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_q     <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_fire;
         if (rd_fire) begin
            rd_q <= rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] out_q;
         logic                  out_vld_q;

         // Optional output pipeline stage, loaded only by a completing read
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               out_q     <= '0;
               out_vld_q <= 1'b0;
            end else begin
               out_vld_q <= rd_vld_q;
               if (rd_vld_q) begin
                  out_q <= rd_q;
               end
            end
         end

         assign doutb       = out_q;
         assign doutb_valid = out_vld_q;
      end else begin : g_no_out_reg
         assign doutb       = rd_q;
         assign doutb_valid = rd_vld_q;
      end
   endgenerate

endmodule
